conv_sequencer: RTL and testbench
=================================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter DATA_LEN, default 40: number of 16-bit words per convolution window.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles spent waiting for conv completion.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_in_valid  input  1  upstream sample valid.
REQ-006 o_in_ready  output  1  block accepts a sample this cycle.
REQ-007 i_in_data  input  16  signed sample; word index = arrival order.
REQ-008 o_conv_start  output  1  one-cycle start pulse to convolution engine.
REQ-009 o_conv_data  output  16 x DATA_LEN  window buffer, index 0..DATA_LEN-1.
REQ-010 i_conv_weights  input  24 x 3  convolution results.
REQ-011 i_conv_finished  input  1  one-cycle completion pulse from engine.
REQ-012 o_out_valid  output  1  captured results valid downstream.
REQ-013 i_out_ready  input  1  downstream accepts results.
REQ-014 o_out_weights  output  24 x 3  captured results, stable while o_out_valid.
REQ-015 o_timeout  output  1  one-cycle pulse when engine fails to finish.

Function
REQ-016 States S_FILL, S_START, S_WAIT, S_OUT; state register 2 bits.
REQ-017 S_FILL: o_in_ready=1; on i_in_valid&&o_in_ready, write i_in_data to buffer[wr_cnt], wr_cnt increments.
REQ-018 Acceptance of word DATA_LEN-1: wr_cnt clears to 0, next state S_START; no further word accepted that cycle or until S_FILL re-entered.
REQ-019 S_START: o_conv_start=1 for exactly one cycle, timeout counter cleared, next state S_WAIT.
REQ-020 S_WAIT: o_in_ready=0; buffer contents held unchanged (engine reads o_conv_data combinationally throughout).
REQ-021 S_WAIT, i_conv_finished=1: capture i_conv_weights[0..2] into o_out_weights on that edge, next state S_OUT.
REQ-022 S_WAIT, i_conv_finished=0: timeout counter increments; when it reaches TIMEOUT-1 without finished, o_timeout pulses one cycle, o_out_weights unchanged, next state S_FILL.
REQ-023 i_conv_finished outside S_WAIT: ignored, no state or output change.
REQ-024 S_OUT: o_out_valid=1; o_out_weights held; on i_out_ready=1 next state S_FILL, o_out_valid deasserts next cycle.
REQ-025 o_in_ready=0 in S_START, S_WAIT, S_OUT; upstream valid held off (no drop, no buffering beyond window).
REQ-026 o_conv_start, o_out_valid, o_in_ready, o_timeout are decoded from registered state/counters only (no combinational path from inputs).
REQ-027 Latency: last sample accept edge -> o_conv_start high next cycle; i_conv_finished edge -> o_out_valid high next cycle.
REQ-028 Buffer re-fills from index 0 each window; words not rewritten keep prior values (no clear between windows).
REQ-029 wr_cnt width = clog2(DATA_LEN); no wrap other than REQ-018.

Reset
REQ-030 i_rst_n low (any time, including mid-fill or S_WAIT): state=S_FILL, wr_cnt=0, timeout counter=0, buffer all 0, o_out_weights all 0, o_conv_start=0, o_out_valid=0, o_timeout=0, o_in_ready=1 after release.
REQ-031 Reset release: first sample accepted on first rising edge with i_in_valid=1.

Structure
REQ-032 Shared package holds state enum (S_FILL..S_OUT), DATA_W=16, WEIGHT_W=24, N_WEIGHTS=3, default DATA_LEN/TIMEOUT constants; reused by the convolution engine integration.
REQ-033 One sub-module: conv_window_buf (DATA_LEN x 16 register file, write enable + index, full parallel read); FSM and counters in conv_sequencer.

Verification
REQ-034 Stream 40 samples 1..40 with valid always high -> o_in_ready drops after 40th, o_conv_start one pulse next cycle, o_conv_data[k]=k+1.
REQ-035 Engine model returns finished 4 cycles after start with weights {24'h000100, 24'hFFFF00, 24'h123456} -> o_out_valid next cycle with those values; hold i_out_ready=0 10 cycles -> values stable; ready=1 -> back to S_FILL.
REQ-036 Engine never finishes -> o_timeout pulses exactly once 16 cycles after start, o_out_valid never asserts, o_in_ready=1 afterwards.
REQ-037 Gapped upstream valid (every 3rd cycle) -> exactly 40 accepts, correct order, start only after 40th.
REQ-038 Assert i_rst_n=0 in S_WAIT after 20 samples of next window -> all outputs reset values, spurious finished after release ignored, next window starts at index 0.
REQ-039 Pulse i_conv_finished during S_FILL -> no capture, no o_out_valid.

Source files
------------

// File: rtl/conv_sequencer_pkg.sv
// Shared types and constants for the convolution sequencer and the engine integration around it.
package conv_sequencer_pkg;

  localparam int unsigned DATA_W           = 16;
  localparam int unsigned WEIGHT_W         = 24;
  localparam int unsigned N_WEIGHTS        = 3;
  localparam int unsigned DEFAULT_DATA_LEN = 40;
  localparam int unsigned DEFAULT_TIMEOUT  = 16;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  typedef logic [N_WEIGHTS-1:0][WEIGHT_W-1:0] weights_t;

  // Counter width able to index n items; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_buf.sv
// Window register file: one indexed write port, every word visible in parallel.
module conv_window_buf
  import conv_sequencer_pkg::*;
#(
  parameter int unsigned DATA_LEN = DEFAULT_DATA_LEN,
  localparam int unsigned IDX_W   = cnt_width(DATA_LEN)
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_wr_en,
  input  logic [IDX_W-1:0]                  i_wr_idx,
  input  logic [DATA_W-1:0]                 i_wr_data,
  output logic [DATA_LEN-1:0][DATA_W-1:0]   o_data
);

  // Words not rewritten in a window keep their previous contents.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
    end else if (i_wr_en) begin
      o_data[i_wr_idx] <= i_wr_data;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Collects a window of samples, kicks the convolution engine, and hands its results downstream
// with a bounded wait for completion.
module conv_sequencer
  import conv_sequencer_pkg::*;
#(
  parameter int unsigned DATA_LEN = DEFAULT_DATA_LEN,
  parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_in_valid,
  output logic                              o_in_ready,
  input  logic [DATA_W-1:0]                 i_in_data,
  output logic                              o_conv_start,
  output logic [DATA_LEN-1:0][DATA_W-1:0]   o_conv_data,
  input  weights_t                          i_conv_weights,
  input  logic                              i_conv_finished,
  output logic                              o_out_valid,
  input  logic                              i_out_ready,
  output weights_t                          o_out_weights,
  output logic                              o_timeout
);

  localparam int unsigned CNT_W = cnt_width(DATA_LEN);
  localparam int unsigned TO_W  = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_LEN - 1);
  // Pulse on the edge where the wait counter steps onto TIMEOUT-1.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);

  state_e           state;
  logic [CNT_W-1:0] wr_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             accept_c;

  assign accept_c = i_in_valid && o_in_ready && (state == S_FILL);

  conv_window_buf #(
    .DATA_LEN (DATA_LEN)
  ) u_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (accept_c),
    .i_wr_idx  (wr_cnt),
    .i_wr_data (i_in_data),
    .o_data    (o_conv_data)
  );

  // Sequencer FSM; every handshake output is a register so nothing flows from inputs to outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_FILL;
      wr_cnt        <= '0;
      to_cnt        <= '0;
      o_in_ready    <= 1'b1;
      o_conv_start  <= 1'b0;
      o_out_valid   <= 1'b0;
      o_timeout     <= 1'b0;
      o_out_weights <= '0;
    end else begin
      o_conv_start <= 1'b0;
      o_timeout    <= 1'b0;
      case (state)
        S_FILL: begin
          if (accept_c) begin
            if (wr_cnt == LAST_IDX) begin
              wr_cnt       <= '0;
              o_in_ready   <= 1'b0;
              o_conv_start <= 1'b1;
              state        <= S_START;
            end else begin
              wr_cnt <= wr_cnt + CNT_W'(1);
            end
          end
        end
        S_START: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (i_conv_finished) begin
            o_out_weights <= i_conv_weights;
            o_out_valid   <= 1'b1;
            state         <= S_OUT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (to_cnt == TO_LAST) begin
              o_timeout  <= 1'b1;
              o_in_ready <= 1'b1;
              state      <= S_FILL;
            end
          end
        end
        S_OUT: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            o_in_ready  <= 1'b1;
            state       <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: fill, engine handshake, timeout, gapped input, resets.
module tb_conv_sequencer;
  import conv_sequencer_pkg::*;

  localparam int unsigned DATA_LEN = 40;

  logic                              clk;
  logic                              rst_n;
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_W-1:0]                 in_data;
  logic                              conv_start;
  logic [DATA_LEN-1:0][DATA_W-1:0]   conv_data;
  weights_t                          conv_weights;
  logic                              conv_finished;
  logic                              out_valid;
  logic                              out_ready;
  weights_t                          out_weights;
  logic                              timeout;

  int n_cmp = 0;
  int n_err = 0;

  conv_sequencer #(
    .DATA_LEN (DATA_LEN),
    .TIMEOUT  (16)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_in_valid      (in_valid),
    .o_in_ready      (in_ready),
    .i_in_data       (in_data),
    .o_conv_start    (conv_start),
    .o_conv_data     (conv_data),
    .i_conv_weights  (conv_weights),
    .i_conv_finished (conv_finished),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_out_weights   (out_weights),
    .o_timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer count words first..first+count-1, valid on every gap-th cycle; returns just
  // before the edge that accepts the last word, with valid still high.
  task automatic send_window(input int first, input int count, input int gap);
    int acc = 0;
    int cyc = 0;
    int early = 0;
    while (acc < count && cyc < 2000) begin
      @(negedge clk);
      if (conv_start) early++;
      in_valid = ((cyc % gap) == 0);
      in_data  = 16'(first + acc);
      if (in_valid && in_ready) acc++;
      cyc++;
    end
    check("fill_accepts", 72'(acc), 72'(count));
    check("start_during_fill", 72'(early), 72'd0);
  endtask

  // Cycle after the last accept: start pulse up, ready down, extra valid word refused.
  task automatic end_window();
    @(negedge clk);
    check("start_after_last", 72'(conv_start), 72'd1);
    check("ready_after_last", 72'(in_ready), 72'd0);
    in_data  = 16'hDEAD;
    @(negedge clk);
    check("start_one_cycle", 72'(conv_start), 72'd0);
    in_valid = 1'b0;
  endtask

  task automatic check_window(input string tag, input int first);
    for (int k = 0; k < int'(DATA_LEN); k++)
      check($sformatf("%s[%0d]", tag, k), 72'(conv_data[k]), 72'(16'(first + k)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 72'(in_ready), 72'd1);
    check({tag, "_start"}, 72'(conv_start), 72'd0);
    check({tag, "_out_valid"}, 72'(out_valid), 72'd0);
    check({tag, "_timeout"}, 72'(timeout), 72'd0);
    check({tag, "_weights"}, 72'(out_weights), 72'd0);
    check({tag, "_buf_zero"}, 72'(|conv_data), 72'd0);
  endtask

  weights_t w35;
  weights_t w37;
  weights_t wjunk;
  int bad;
  int to_cnt;
  int to_at;
  int ov_cnt;

  initial begin
    w35   = {24'h123456, 24'hFFFF00, 24'h000100};
    w37   = {24'h00000C, 24'h00000B, 24'h00000A};
    wjunk = {3{24'hABCDEF}};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    conv_weights = '0; conv_finished = 1'b0; out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Contiguous window 1..40
    send_window(1, 40, 1);
    end_window();
    check_window("buf_seq", 1);

    // Engine answers four cycles after start; downstream stalls for ten cycles
    repeat (3) @(negedge clk);
    check("ov_before_finish", 72'(out_valid), 72'd0);
    conv_finished = 1'b1; conv_weights = w35;
    @(negedge clk);
    conv_finished = 1'b0; conv_weights = '0;
    check("ov_after_finish", 72'(out_valid), 72'd1);
    check("w0", 72'(out_weights[0]), 72'h000100);
    check("w1", 72'(out_weights[1]), 72'hFFFF00);
    check("w2", 72'(out_weights[2]), 72'h123456);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_weights !== w35 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("hold_stable", 72'(bad), 72'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_ov_low", 72'(out_valid), 72'd0);
    check("drain_ready", 72'(in_ready), 72'd1);

    // Engine never finishes: single timeout pulse 16 cycles after the start pulse
    send_window(201, 40, 1);
    end_window();
    to_cnt = 0; to_at = 0; ov_cnt = 0;
    for (int n = 2; n <= 20; n++) begin
      @(negedge clk);
      if (timeout) begin to_cnt++; to_at = n; end
      if (out_valid) ov_cnt++;
    end
    check("timeout_count", 72'(to_cnt), 72'd1);
    check("timeout_cycle", 72'(to_at), 72'd16);
    check("timeout_no_ov", 72'(ov_cnt), 72'd0);
    check("timeout_ready", 72'(in_ready), 72'd1);
    check("timeout_w_held", 72'(out_weights), 72'(w35));

    // Stray finished while filling is ignored
    conv_finished = 1'b1; conv_weights = wjunk;
    @(negedge clk);
    conv_finished = 1'b0; conv_weights = '0;
    @(negedge clk);
    check("fill_fin_ov", 72'(out_valid), 72'd0);
    check("fill_fin_w", 72'(out_weights), 72'(w35));

    // Gapped upstream: valid every third cycle
    send_window(301, 40, 3);
    end_window();
    check_window("buf_gap", 301);
    conv_finished = 1'b1; conv_weights = w37;
    @(negedge clk);
    conv_finished = 1'b0; conv_weights = '0;
    check("gap_ov", 72'(out_valid), 72'd1);
    check("gap_w", 72'(out_weights), 72'(w37));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("gap_drain", 72'(out_valid), 72'd0);

    // Reset while waiting on the engine
    send_window(401, 40, 1);
    end_window();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    conv_finished = 1'b1; conv_weights = wjunk;
    @(negedge clk);
    conv_finished = 1'b0; conv_weights = '0;
    @(negedge clk);
    check("post_rst_fin_ov", 72'(out_valid), 72'd0);
    check("post_rst_fin_w", 72'(out_weights), 72'd0);

    // Partial window restarts at index 0, then reset mid-fill
    send_window(501, 20, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("part_w0", 72'(conv_data[0]), 72'(16'd501));
    check("part_w19", 72'(conv_data[19]), 72'(16'd520));
    check("part_w20", 72'(conv_data[20]), 72'd0);
    check("part_ready", 72'(in_ready), 72'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_fill");
    @(negedge clk);
    rst_n = 1'b1;
    send_window(601, 40, 1);
    end_window();
    check("refill_w0", 72'(conv_data[0]), 72'(16'd601));
    check("refill_w39", 72'(conv_data[39]), 72'(16'd640));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
